// File: rtl/mux_nx1_seq_hs.sv
// mux_nx1_seq_hs
// N:1 multiplexer with valid/ready handshaking on every input and on the
// output, followed by a small FIFO output buffer. The channel is chosen
// either by an explicit command or by a round-robin arbiter that only
// considers valid inputs.
//
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   i_valid      per-channel valid (bit k = channel k)
//   i_data_bus   channel k payload at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_ready      per-channel ready (combinational, at most one bit set)
//   i_en         acceptance enable (draining continues while low)
//   i_mode       0 = command select, 1 = round-robin
//   i_cmd        channel index used when i_mode = 0
//   o_valid      buffer non-empty
//   o_data_bus   head of buffer, zero when o_valid = 0
//   i_ready      downstream ready
//   o_sel        channel of the most recently accepted beat
//   o_count      buffer occupancy
module mux_nx1_seq_hs #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_INPUTS     = 4,
  parameter int COMMMAND_WIDTH = $clog2(NUM_INPUTS),
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_INPUTS-1:0]              i_valid,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0]   i_data_bus,
  output logic [NUM_INPUTS-1:0]              o_ready,
  input  logic                               i_en,
  input  logic                               i_mode,
  input  logic [COMMMAND_WIDTH-1:0]          i_cmd,
  output logic                               o_valid,
  output logic [DATA_WIDTH-1:0]              o_data_bus,
  input  logic                               i_ready,
  output logic [COMMMAND_WIDTH-1:0]          o_sel,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [DATA_WIDTH-1:0]     mem_reg [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr_reg;
  logic [PTR_W-1:0]          rd_ptr_reg;
  logic [CNT_W-1:0]          count_reg;
  logic [COMMMAND_WIDTH-1:0] rr_ptr_reg;
  logic [COMMMAND_WIDTH-1:0] rr_ptr_next;
  logic [COMMMAND_WIDTH-1:0] sel_reg;

  logic [DATA_WIDTH-1:0]     ch_data [NUM_INPUTS];
  logic                      grant_valid;
  logic [COMMMAND_WIDTH-1:0] grant_idx;
  int                        cand;
  logic                      full;
  logic                      empty;
  logic                      accept_ok;
  logic [NUM_INPUTS-1:0]     push_vec;
  logic                      push;
  logic                      pop;
  logic [DATA_WIDTH-1:0]     wr_data;

  assign full      = (count_reg == CNT_W'(FIFO_DEPTH));
  assign empty     = (count_reg == '0);
  assign accept_ok = grant_valid & i_en & ~full & ~rst;

  // Grant selection. In round-robin mode the loop runs from the farthest
  // offset down to zero so the last hit, i.e. the nearest valid channel
  // at or after rr_ptr, is the one that sticks.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    if (!i_mode) begin
      if (int'(i_cmd) < NUM_INPUTS) begin
        grant_valid = 1'b1;
        grant_idx   = i_cmd;
      end
    end else begin
      for (int off = NUM_INPUTS - 1; off >= 0; off--) begin
        cand = (int'(rr_ptr_reg) + off) % NUM_INPUTS;
        if (i_valid[cand]) begin
          grant_valid = 1'b1;
          grant_idx   = COMMMAND_WIDTH'(cand);
        end
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
      assign ch_data[gi]  = i_data_bus[gi*DATA_WIDTH +: DATA_WIDTH];
      assign o_ready[gi]  = accept_ok & (grant_idx == COMMMAND_WIDTH'(gi));
      assign push_vec[gi] = o_ready[gi] & i_valid[gi];
    end
  endgenerate

  assign push = |push_vec;
  assign pop  = ~empty & i_ready;

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (grant_idx == COMMMAND_WIDTH'(k)) wr_data = ch_data[k];
    end
  end

  assign rr_ptr_next = (int'(grant_idx) == NUM_INPUTS - 1) ? '0
                                                           : grant_idx + COMMMAND_WIDTH'(1);

  // Buffer storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      rr_ptr_reg <= '0;
      sel_reg    <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        sel_reg    <= grant_idx;
        if (i_mode) rr_ptr_reg <= rr_ptr_next;
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign o_valid    = ~empty;
  assign o_data_bus = empty ? '0 : mem_reg[rd_ptr_reg];
  assign o_sel      = sel_reg;
  assign o_count    = count_reg;

endmodule

// File: tb/tb_mux_nx1_seq_hs.sv
// Testbench for mux_nx1_seq_hs: directed scenarios plus a random phase.
// Stimulus pushes expected beats into a queue; a separate monitor pops and
// compares whenever the output handshake completes.
module tb_mux_nx1_seq_hs;
  localparam int DW = 32, N = 4, CW = 2, DEPTH = 2, CNTW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    valid;
  logic [N*DW-1:0] data;
  logic            en, mode, rdy;
  logic [CW-1:0]   cmd;
  logic [N-1:0]    o_ready;
  logic            o_valid;
  logic [DW-1:0]   o_data;
  logic [CW-1:0]   o_sel;
  logic [CNTW-1:0] o_count;

  // Second instance with three channels for the out-of-range command case.
  logic [2:0]      v3;
  logic [3*DW-1:0] d3;
  logic            en3, rdy3, mode3;
  logic [1:0]      cmd3;
  logic [2:0]      r3;
  logic            ov3;
  logic [DW-1:0]   od3;
  logic [1:0]      os3;
  logic [1:0]      oc3;

  mux_nx1_seq_hs #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .i_valid(valid), .i_data_bus(data), .o_ready(o_ready),
    .i_en(en), .i_mode(mode), .i_cmd(cmd), .o_valid(o_valid), .o_data_bus(o_data),
    .i_ready(rdy), .o_sel(o_sel), .o_count(o_count)
  );

  mux_nx1_seq_hs #(.DATA_WIDTH(DW), .NUM_INPUTS(3), .FIFO_DEPTH(2)) dut3 (
    .clk(clk), .rst(rst), .i_valid(v3), .i_data_bus(d3), .o_ready(r3),
    .i_en(en3), .i_mode(mode3), .i_cmd(cmd3), .o_valid(ov3), .o_data_bus(od3),
    .i_ready(rdy3), .o_sel(os3), .o_count(oc3)
  );

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  int m_rr = 0;
  int m_sel = 0;
  bit started = 1'b0;
  bit pend;
  int seq [6] = '{0, 1, 3, 0, 1, 3};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference grant: command index if in range, otherwise the first valid
  // channel found walking circularly from the round-robin pointer.
  function automatic int model_grant();
    int k;
    if (!mode) return (int'(cmd) < N) ? int'(cmd) : -1;
    for (int off = 0; off < N; off++) begin
      k = (m_rr + off) % N;
      if (valid[k]) return k;
    end
    return -1;
  endfunction

  task automatic cycle();
    int g;
    logic [N-1:0] er;
    bit push;
    @(negedge clk);
    g = model_grant();
    er = '0;
    push = 1'b0;
    if (g >= 0 && en && !rst && exp_q.size() < DEPTH) begin
      er[g] = 1'b1;
      push = valid[g];
    end
    chk("o_ready", o_ready, er);
    chk("o_sel", o_sel, m_sel);
    $display("cyc rst=%0b mode=%0b cmd=%0d valid=%b en=%0b rdy=%0b exp_ready=%b push=%0b q=%0d",
             rst, mode, cmd, valid, en, rdy, er, push, exp_q.size());
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_rr = 0;
      m_sel = 0;
    end else if (push) begin
      exp_q.push_back(data[g*DW +: DW]);
      m_sel = g;
      if (mode) m_rr = (g + 1) % N;
    end
    #1;
  endtask

  // Monitor: output side compared against the queue head, popped on handshake.
  initial begin
    forever begin
      @(negedge clk);
      pend = 1'b0;
      if (started) begin
        chk("o_valid", o_valid, exp_q.size() != 0);
        chk("o_count", o_count, exp_q.size());
        if (exp_q.size() == 0) chk("o_data_idle", o_data, 0);
        else begin
          chk("o_data", o_data, exp_q[0]);
          pend = rdy;
        end
      end
      @(posedge clk);
      if (pend && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    rst = 1'b1; valid = '1; en = 1'b1; mode = 1'b0; cmd = '0; rdy = 1'b1;
    data = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hBBBB_BBBB, 32'hAAAA_AAAA};
    v3 = '0; d3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    en3 = 1'b0; rdy3 = 1'b1; mode3 = 1'b0; cmd3 = '0;
    @(posedge clk); #1;
    started = 1'b1;

    // Reset held with all inputs active, then idle with enable low.
    repeat (2) cycle();
    rst = 1'b0; en = 1'b0;
    repeat (3) cycle();

    // Command select, streaming one beat per cycle.
    en = 1'b1; mode = 1'b0; cmd = 2; valid = '1; rdy = 1'b1;
    cycle();
    chk("t2_sel", o_sel, 2);
    chk("t2_head", o_data, 32'hCCCC_CCCC);
    repeat (4) begin
      data[2*DW +: DW] = $urandom;
      cycle();
    end

    // Backpressure fills the buffer, then drain.
    cmd = 1; rdy = 1'b0; data[DW +: DW] = 32'h1111_0001;
    cycle();
    data[DW +: DW] = 32'h1111_0002;
    repeat (3) cycle();
    chk("t3_full", o_count, 2);
    valid = '0; rdy = 1'b1;
    cycle();
    chk("t3_count1", o_count, 1);
    chk("t3_ready_back", o_ready, 4'b0010);
    cycle();
    chk("t3_count0", o_count, 0);

    // Round-robin over channels 0, 1, 3.
    mode = 1'b1; valid = 4'b1011; rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      data = {$urandom, $urandom, $urandom, $urandom};
      cycle();
      chk("t4_sel", o_sel, seq[i]);
    end

    // Command to an idle channel: ready shown, nothing pushed.
    mode = 1'b0; cmd = 3; valid = 4'b0111;
    cycle();
    chk("t5_ready", o_ready, 4'b1000);
    chk("t5_nopush", o_count, 0);

    // Out-of-range command on the three-channel instance.
    en = 1'b0;
    en3 = 1'b1; cmd3 = 3; v3 = 3'b111;
    repeat (2) begin
      @(negedge clk);
      chk("t5_oor_ready", r3, 3'b000);
      @(posedge clk); #1;
      chk("t5_oor_valid", ov3, 1'b0);
    end
    cmd3 = 2;
    @(negedge clk);
    chk("t5_n3_ready", r3, 3'b100);
    @(posedge clk); #1;
    chk("t5_n3_valid", ov3, 1'b1);
    chk("t5_n3_data", od3, 32'h3333_0002);
    chk("t5_n3_sel", os3, 2);
    en3 = 1'b0;

    // Fill under round-robin, reset mid-drain, pointer restarts at 0.
    en = 1'b1; mode = 1'b1; valid = 4'b0001; rdy = 1'b0;
    data[0 +: DW] = 32'hDEAD_0000;
    repeat (3) cycle();
    chk("t6_full", o_count, 2);
    valid = '0; rdy = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("t6_valid", o_valid, 1'b0);
    chk("t6_count", o_count, 0);
    valid = '1; data = {32'h6666_0003, 32'h6666_0002, 32'h6666_0001, 32'h6666_0000};
    cycle();
    chk("t6_rr_restart", o_sel, 0);

    // Random traffic.
    repeat (600) begin
      valid = N'($urandom);
      mode  = 1'($urandom);
      cmd   = CW'($urandom);
      en    = ($urandom_range(0, 9) < 8);
      rdy   = ($urandom_range(0, 9) < 6);
      rst   = ($urandom_range(0, 99) == 0);
      data  = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
